// File: rtl/hazard_sched_pkg.sv
// Shared encodings for the pipeline hazard scheduler.
package hazard_sched_pkg;

  // Operand source select driven to the ID-stage operand muxes
  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXALU = 2'd1,
    FWD_MEMALU = 2'd2,
    FWD_MEMLD = 2'd3
  } fwd_e;

  typedef enum logic [1:0] {
    DBG_RUN  = 2'd0,
    DBG_HALT = 2'd1,
    DBG_STEP = 2'd2
  } dbg_state_e;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  localparam int unsigned MDU_CNT_W = 4;

  // Pick the youngest in-flight producer of a source register
  function automatic fwd_e fwd_sel(
    input logic [4:0] src,
    input logic [4:0] ex_dest,  input logic ex_w,  input logic ex_ld,
    input logic [4:0] mem_dest, input logic mem_w, input logic mem_ld
  );
    fwd_e sel;
    sel = FWD_RF;
    if (src != 5'd0) begin
      if (ex_w && (ex_dest == src) && !ex_ld) sel = FWD_EXALU;
      else if (mem_w && (mem_dest == src))    sel = mem_ld ? FWD_MEMLD : FWD_MEMALU;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_sched_mdu.sv
// MDU occupancy tracker: counts down MDU_LAT cycles after each start pulse.
module mdu_sched
  import hazard_sched_pkg::*;
#(
  parameter int unsigned MDU_LAT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic last_cycle
);

  mdu_state_e           state_q, state_d;
  logic [MDU_CNT_W-1:0] cnt_q, cnt_d;

  // Next state: a start (even in the final busy cycle) reloads the counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (start) begin
      state_d = MDU_BUSY;
      cnt_d   = MDU_CNT_W'(MDU_LAT - 1);
    end else if (state_q == MDU_BUSY) begin
      if (cnt_q == '0) state_d = MDU_IDLE;
      else             cnt_d   = cnt_q - 1'b1;
    end
  end

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy       = (state_q == MDU_BUSY);
  assign last_cycle = busy && (cnt_q == '0);

endmodule

// File: rtl/hazard_sched.sv
// Pipeline sequencing: forwarding selects, load/MDU/debug stalls, branch flush.
module hazard_sched
  import hazard_sched_pkg::*;
#(
  parameter int unsigned MDU_LAT = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_branch_taken,
  input  logic             id_mdu_op,
  input  logic             id_use_hilo,
  input  logic [4:0]       ex_destR,
  input  logic             ex_wreg,
  input  logic             ex_m2reg,
  input  logic [4:0]       mem_destR,
  input  logic             mem_wreg,
  input  logic             mem_m2reg,
  input  logic             dbg_halt,
  input  logic             dbg_step,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             mdu_start,
  output logic             mdu_busy,
  output logic             dbg_halted,
  output logic [CNT_W-1:0] stall_cnt
);

  dbg_state_e       dbg_state_q, dbg_state_d;
  logic             dbg_halted_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             mdu_last;
  logic             load_haz, mdu_haz, dbg_haz, core_stall, stall;

  mdu_sched #(.MDU_LAT(MDU_LAT)) u_mdu (
    .clk        (clk),
    .rst        (rst),
    .start      (mdu_start),
    .busy       (mdu_busy),
    .last_cycle (mdu_last)
  );

  // Operand forwarding and stall/flush decisions
  always_comb begin
    fwda = fwd_sel(id_rs, ex_destR, ex_wreg, ex_m2reg, mem_destR, mem_wreg, mem_m2reg);
    fwdb = fwd_sel(id_rt, ex_destR, ex_wreg, ex_m2reg, mem_destR, mem_wreg, mem_m2reg);
    load_haz = ex_wreg && ex_m2reg && (ex_destR != 5'd0) &&
               ((id_use_rs && (ex_destR == id_rs)) || (id_use_rt && (ex_destR == id_rt)));
    // The final busy cycle lets a waiting HI/LO reader or new mult go
    mdu_haz    = (id_mdu_op || id_use_hilo) && mdu_busy && !mdu_last;
    dbg_haz    = (dbg_state_q == DBG_HALT);
    core_stall = load_haz || mdu_haz;
    stall      = core_stall || dbg_haz;
    pc_we       = !stall;
    ifid_we     = !stall;
    idex_bubble = stall;
    ifid_flush  = id_branch_taken && !stall;
    mdu_start   = id_mdu_op && !stall;
  end

  // Debug sequencer: a step lingers until one instruction actually advances
  always_comb begin
    dbg_state_d = dbg_state_q;
    unique case (dbg_state_q)
      DBG_RUN:  if (dbg_halt) dbg_state_d = DBG_HALT;
      DBG_HALT: begin
        if (!dbg_halt)     dbg_state_d = DBG_RUN;
        else if (dbg_step) dbg_state_d = DBG_STEP;
      end
      DBG_STEP: if (!core_stall) dbg_state_d = dbg_halt ? DBG_HALT : DBG_RUN;
      default:  dbg_state_d = DBG_RUN;
    endcase
  end

  // Saturating count of bubble cycles
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (idex_bubble && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // Debug state, registered halted flag and stall counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbg_state_q  <= DBG_RUN;
      dbg_halted_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      dbg_state_q  <= dbg_state_d;
      dbg_halted_q <= (dbg_state_d == DBG_HALT);
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign dbg_halted = dbg_halted_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: doc/hazard_sched.md
Name: hazard_sched

Overview:
- Central pipeline-sequencing controller for the 5-stage MIPS core. Sits beside the decode stage.
- Takes decoded register usage from ID and destination info from EX/MEM. Produces operand-forward selects, load-use and branch-operand stalls, and branch flush.
- Owns a state machine that shares the single multi-cycle multiply/divide unit (MDU) between consecutive instructions.
- Adds a debug halt/single-step sequencer that freezes instruction issue.

Parameters:
- MDU_LAT, 8, cycles the MDU needs from start pulse to result valid (2..15).
- CNT_W, 16, width of the saturating stall performance counter.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- id_rs  input  5  rs field of instruction in ID
- id_rt  input  5  rt field of instruction in ID
- id_use_rs  input  1  ID instruction reads rs (incl. branch/jr compare)
- id_use_rt  input  1  ID instruction reads rt
- id_branch_taken  input  1  ID resolved a taken branch/jump/jr this cycle
- id_mdu_op  input  1  ID instruction is mult/div
- id_use_hilo  input  1  ID instruction is mfhi/mflo
- ex_destR  input  5  destination register of EX instruction
- ex_wreg  input  1  EX instruction writes the register file
- ex_m2reg  input  1  EX instruction is a load
- mem_destR  input  5  destination register of MEM instruction
- mem_wreg  input  1  MEM instruction writes the register file
- mem_m2reg  input  1  MEM instruction is a load
- dbg_halt  input  1  level request to freeze issue
- dbg_step  input  1  one-cycle pulse, release one instruction while halted
- fwda  output  2  rs source select: 0 regfile, 1 ex_aluR, 2 mem_aluR, 3 mem_mdata
- fwdb  output  2  rt source select, same encoding
- pc_we  output  1  PC register write enable
- ifid_we  output  1  IF/ID latch enable
- ifid_flush  output  1  replace IF/ID contents with nop
- idex_bubble  output  1  inject nop into ID/EX
- mdu_start  output  1  one-cycle start pulse to MDU
- mdu_busy  output  1  MDU occupied
- dbg_halted  output  1  issue is frozen
- stall_cnt  output  CNT_W  count of cycles with idex_bubble=1, saturating

Behaviour:
- Reset, asynchronous: FSM state RUN, MDU state IDLE, MDU counter 0, stall_cnt 0. Combinational outputs evaluate with these states: pc_we=1, ifid_we=1, others 0 given idle inputs.
- Forward select (combinational, per operand; rs shown, rt identical):
  - Register 0 never forwards.
  - If ex_wreg, ex_destR==id_rs and !ex_m2reg: select 1.
  - Else if mem_wreg and mem_destR==id_rs: select 3 when mem_m2reg, else 2.
  - Else select 0.
  - EX match has priority over MEM match.
- Hazard terms:
  - load_haz = an operand is used, matches ex_destR, and ex_wreg & ex_m2reg.
  - mdu_haz = (id_mdu_op | id_use_hilo) while MDU is BUSY.
  - dbg_haz = issue frozen by the debug FSM.
  - stall = load_haz | mdu_haz | dbg_haz.
- On stall: pc_we=0, ifid_we=0, idex_bubble=1, ifid_flush=0, mdu_start=0.
- Flush: ifid_flush = id_branch_taken & !stall. A stalled branch is not taken until its operands are ready.
- MDU FSM, IDLE -> BUSY:
  - Enter BUSY on mdu_start.
  - mdu_start = id_mdu_op & !stall, with state IDLE (or BUSY in the final cycle; see below).
  - On start the counter loads MDU_LAT-1 and decrements each cycle.
  - BUSY -> IDLE when counter==0.
  - In that final BUSY cycle, mdu_haz is deasserted. A waiting mfhi/mult issues that cycle; a new mult re-enters BUSY with the counter reloaded.
  - mdu_busy=1 in BUSY.
- Debug FSM:
  - RUN -> HALT when dbg_halt=1.
  - In HALT: dbg_halted=1, dbg_haz=1.
  - HALT + dbg_step -> STEP: dbg_haz=0 for exactly one cycle.
  - STEP -> HALT if dbg_halt still 1, else RUN.
  - HALT -> RUN when dbg_halt=0.
  - A dbg_step in RUN is ignored.
  - A step cycle is still subject to load/MDU stalls. If stalled, STEP remains until one instruction advances.
- stall_cnt increments when idex_bubble=1 and holds at all-ones.
- Simultaneous events:
  - Reset mid-MDU-operation returns to IDLE and does not pulse mdu_start.
  - dbg_halt asserted during BUSY freezes issue, but the MDU counter keeps running.

Decomposition:
- Shared package:
  - FWD_* encodings (0..3).
  - Debug FSM state constants RUN/HALT/STEP.
  - MDU state constants IDLE/BUSY.
- Sub-module mdu_sched holds the MDU FSM and counter. Interface: start in; busy, last_cycle out.
- Forwarding and debug logic stay in the top module.

Test Plan:
- ALU then dependent add: ex_wreg=1, ex_destR=5, ex_m2reg=0, id_rs=5 -> fwda=1, no stall. Same match in MEM only -> fwda=2. MEM load match -> fwda=3.
- lw $4 in EX, beq $4,$0 in ID with id_branch_taken=1 -> one cycle pc_we=0, idex_bubble=1, ifid_flush=0. Next cycle (load in MEM) fwda=3, ifid_flush=1.
- mult, then mflo next, MDU_LAT=8 -> mdu_start one pulse. mflo stalls 7 cycles and issues on the 8th BUSY cycle. stall_cnt=7.
- Back-to-back mult, mult -> second start pulses in the final BUSY cycle of the first. mdu_busy stays 1 for 16 cycles total.
- dbg_halt=1 for 10 cycles with one dbg_step at cycle 4 -> exactly one cycle of pc_we=1. dbg_halted=1 otherwise. RUN resumes after dbg_halt falls.
- rst asserted mid-BUSY -> mdu_busy=0, stall_cnt=0, dbg_halted=0 immediately. No mdu_start after release unless a new id_mdu_op arrives.
